// File: rtl/wide_uart_seq_pkg.sv
// wide_uart_seq_pkg
// Shared definitions for the wide UART DUT sequencer:
//   - control-byte opcode values
//   - FSM state encoding
//   - bit positions of the response status byte and a helper to pack it
package wide_uart_seq_pkg;

  localparam logic [1:0] OP_PING       = 2'b00;
  localparam logic [1:0] OP_EXEC       = 2'b01;
  localparam logic [1:0] OP_EXEC_QUIET = 2'b10;
  localparam logic [1:0] OP_RSVD       = 2'b11;

  localparam int ST_ERR    = 7;
  localparam int ST_TMO    = 6;
  localparam int ST_TGT_HI = 5;
  localparam int ST_TGT_LO = 4;
  localparam int ST_SEQ_HI = 3;
  localparam int ST_SEQ_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_START,
    S_WAIT_DONE,
    S_LOAD_TX,
    S_TX_REQ,
    S_TX_WAIT,
    S_ACK
  } state_t;

  function automatic logic [7:0] make_status(input logic       err,
                                             input logic       tmo,
                                             input logic [1:0] tgt,
                                             input logic [3:0] seq);
    logic [7:0] s;
    s = '0;
    s[ST_ERR]              = err;
    s[ST_TMO]              = tmo;
    s[ST_TGT_HI:ST_TGT_LO] = tgt;
    s[ST_SEQ_HI:ST_SEQ_LO] = seq;
    return s;
  endfunction

endpackage

// File: rtl/wide_uart_seq_timer.sv
// wide_uart_seq_timer
// Loadable down-counter used as the DUT timeout timer. Saturates at zero.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        load count with load_value (has priority over dec)
//   load_value  reload value
//   dec         decrement by one when non-zero
//   expired     count is zero
module wide_uart_seq_timer #(
  parameter int TIMER_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [TIMER_BITS-1:0] load_value,
  input  logic                  dec,
  output logic                  expired
);

  logic [TIMER_BITS-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - TIMER_BITS'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/wide_uart_dut_sequencer.sv
// wide_uart_dut_sequencer
// Accepts host packets from the wide UART I/O block, decodes the control
// byte, runs one command on a DUT channel (with timeout), returns a status
// byte plus result data and then acknowledges the packet.
//
// Ports:
//   masterClock, reset          clock, asynchronous active-high reset
//   dataReceived/control/inputData   received packet from the UART block
//   clearDR                     packet acknowledge
//   transmit/transmitting       response request / UART busy handshake
//   hostStatus/hostData         response contents
//   dutStart/dutCommand/dutData one-hot start pulse and held operands
//   dutDone/dutResult           per-channel completion and flat result bus
//   busy                        high whenever the FSM is not idle
//
// Build option: define WIDE_UART_SEQ_LOOPBACK_EN to make opcode 11 a
// loopback echo; otherwise opcode 11 is answered with the error flag.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for dataReceived; packet latched on the leaving edge
// DECODE    | classify opcode/target, prepare ping/error/loopback data
// START     | one-cycle dutStart pulse, timer reload
// WAIT_DONE | watch dutDone[target] against the timeout timer
// LOAD_TX   | register hostStatus/hostData, advance sequence number
// TX_REQ    | hold transmit until the UART reports transmitting
// TX_WAIT   | wait for the UART to finish transmitting
// ACK       | hold clearDR until dataReceived drops, then clear flags
module wide_uart_dut_sequencer
  import wide_uart_seq_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int NUM_TARGETS    = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMER_BITS     = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                          masterClock,
  input  logic                          reset,
  input  logic                          dataReceived,
  input  logic [7:0]                    control,
  input  logic [WIDTH*8-1:0]            inputData,
  output logic                          clearDR,
  output logic                          transmit,
  input  logic                          transmitting,
  output logic [7:0]                    hostStatus,
  output logic [WIDTH*8-1:0]            hostData,
  output logic [NUM_TARGETS-1:0]        dutStart,
  output logic [3:0]                    dutCommand,
  output logic [WIDTH*8-1:0]            dutData,
  input  logic [NUM_TARGETS-1:0]        dutDone,
  input  logic [NUM_TARGETS*WIDTH*8-1:0] dutResult,
  output logic                          busy
);

  localparam int W8 = WIDTH * 8;

  state_t          state, next_state;
  logic [7:0]      ctrl_q;
  logic [W8-1:0]   data_in_q;
  logic [W8-1:0]   result_q;
  logic            err_q, tmo_q;
  logic [3:0]      seq_q;

  logic [1:0]      opcode, tgt;
  logic            tgt_bad, done_sel, expired;
  logic            timer_load, timer_dec;
  logic [W8-1:0]   result_sel;

  assign opcode     = ctrl_q[7:6];
  assign tgt        = ctrl_q[5:4];
  assign tgt_bad    = (int'(tgt) >= NUM_TARGETS);
  // Only the addressed channel's done is observed; others are ignored.
  assign done_sel   = dutDone[tgt];
  assign result_sel = dutResult[int'(tgt)*W8 +: W8];

  wide_uart_seq_timer #(
    .TIMER_BITS(TIMER_BITS)
  ) u_timer (
    .clk       (masterClock),
    .rst       (reset),
    .load      (timer_load),
    .load_value(TIMER_BITS'(TIMEOUT_CYCLES)),
    .dec       (timer_dec),
    .expired   (expired)
  );

  always_ff @(posedge masterClock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    dutStart   = '0;
    clearDR    = 1'b0;
    busy       = (state != S_IDLE);
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      S_IDLE:      if (dataReceived) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_PING:                next_state = S_LOAD_TX;
          OP_EXEC, OP_EXEC_QUIET: next_state = tgt_bad ? S_LOAD_TX : S_START;
          OP_RSVD:                next_state = S_LOAD_TX;
        endcase
      end
      S_START: begin
        dutStart   = NUM_TARGETS'(1) << tgt;
        timer_load = 1'b1;
        next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        timer_dec = 1'b1;
        // Done on the expiry cycle takes priority over the timeout.
        if (done_sel)     next_state = (opcode == OP_EXEC_QUIET) ? S_ACK : S_LOAD_TX;
        else if (expired) next_state = S_LOAD_TX;
      end
      S_LOAD_TX:   next_state = S_TX_REQ;
      S_TX_REQ:    if (transmitting) next_state = S_TX_WAIT;
      S_TX_WAIT:   if (!transmitting) next_state = S_ACK;
      S_ACK: begin
        clearDR = 1'b1;
        if (!dataReceived) next_state = S_IDLE;
      end
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge masterClock or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      data_in_q  <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      seq_q      <= '0;
      hostStatus <= '0;
      hostData   <= '0;
      dutCommand <= '0;
      dutData    <= '0;
      transmit   <= 1'b0;
    end else begin
      // Registered so transmit rises one edge after TX_REQ is entered.
      transmit <= (state == S_TX_REQ) && !transmitting;
      case (state)
        S_IDLE: begin
          if (dataReceived) begin
            ctrl_q    <= control;
            data_in_q <= inputData;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_PING: result_q <= data_in_q;
            OP_EXEC, OP_EXEC_QUIET: begin
              if (tgt_bad) begin
                err_q    <= 1'b1;
                result_q <= '0;
              end
            end
            OP_RSVD: begin
`ifdef WIDE_UART_SEQ_LOOPBACK_EN
              result_q <= {data_in_q[W8-1:4], data_in_q[3:0] ^ ctrl_q[3:0]};
`else
              err_q    <= 1'b1;
              result_q <= '0;
`endif
            end
          endcase
        end
        S_START: begin
          dutCommand <= ctrl_q[3:0];
          dutData    <= data_in_q;
        end
        S_WAIT_DONE: begin
          if (done_sel) begin
            result_q <= result_sel;
          end else if (expired) begin
            tmo_q    <= 1'b1;
            result_q <= '0;
          end
        end
        S_LOAD_TX: begin
          hostStatus <= make_status(err_q, tmo_q, tgt, seq_q);
          hostData   <= result_q;
          seq_q      <= seq_q + 4'd1;
        end
        S_ACK: begin
          if (!dataReceived) begin
            err_q <= 1'b0;
            tmo_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_uart_dut_sequencer.sv
module tb_wide_uart_dut_sequencer;

  localparam int WIDTH      = 4;
  localparam int NT         = 3;
  localparam int TMO        = 16;
  localparam int CYC_BUDGET = 200;

  logic          clk;
  logic          reset;
  logic          dataReceived;
  logic [7:0]    control;
  logic [31:0]   inputData;
  logic          clearDR;
  logic          transmit;
  logic          transmitting;
  logic [7:0]    hostStatus;
  logic [31:0]   hostData;
  logic [NT-1:0] dutStart;
  logic [3:0]    dutCommand;
  logic [31:0]   dutData;
  logic [NT-1:0] dutDone;
  logic [NT*32-1:0] dutResult;
  logic          busy;

  wide_uart_dut_sequencer #(
    .WIDTH(WIDTH), .NUM_TARGETS(NT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .masterClock (clk),
    .reset       (reset),
    .dataReceived(dataReceived),
    .control     (control),
    .inputData   (inputData),
    .clearDR     (clearDR),
    .transmit    (transmit),
    .transmitting(transmitting),
    .hostStatus  (hostStatus),
    .hostData    (hostData),
    .dutStart    (dutStart),
    .dutCommand  (dutCommand),
    .dutData     (dutData),
    .dutDone     (dutDone),
    .dutResult   (dutResult),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  ctrl;
    logic [31:0] data;
    int          done_dly;   // cycles after dutStart seen; -1 = never
    logic [31:0] res;
    bit          noise;      // pulse dutDone[0] while waiting
    bit          resp;
    bit          err;
    bit          tmo;
    logic [31:0] exp_data;
    logic [2:0]  exp_start;
    bit          chk_lat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [39:0] sb_q[$];
  logic [3:0]  exp_seq = 4'd0;
  logic        mon_prev = 1'b0;
  vec_t        vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [7:0] c, input logic [31:0] d,
                              input int dly, input logic [31:0] r, input bit noise,
                              input bit resp, input bit err, input bit tmo,
                              input logic [31:0] ed, input logic [2:0] es, input bit lat);
    vec_t v;
    v.name = n; v.ctrl = c; v.data = d; v.done_dly = dly; v.res = r; v.noise = noise;
    v.resp = resp; v.err = err; v.tmo = tmo; v.exp_data = ed; v.exp_start = es;
    v.chk_lat = lat;
    return v;
  endfunction

  // Scoreboard consumer: every rising transmit must match the oldest expectation.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (transmit && !mon_prev) begin
        chk("tx_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          logic [39:0] e;
          e = sb_q.pop_front();
          chk("resp_status", 64'(hostStatus), 64'(e[39:32]));
          chk("resp_data", 64'(hostData), 64'(e[31:0]));
        end
      end
      mon_prev = transmit;
    end
  end

  task automatic send(input vec_t v);
    int         done_at, tx_first, tx_state, tx_cnt, starts;
    logic [2:0] start_mask;
    bit         ack_seen, finished;
    int         t;
    done_at = -1; tx_first = -1; tx_state = 0; tx_cnt = 0; starts = 0;
    start_mask = '0; ack_seen = 0; finished = 0;
    t = int'(v.ctrl[5:4]);
    @(posedge clk); #1;
    if (v.resp) begin
      sb_q.push_back({{v.err, v.tmo, v.ctrl[5:4], exp_seq}, v.exp_data});
      exp_seq = exp_seq + 4'd1;
    end
    control = v.ctrl; inputData = v.data; dataReceived = 1'b1;
    for (int cyc = 0; cyc < CYC_BUDGET && !finished; cyc++) begin
      @(posedge clk); #1;
      if (dutStart != '0) begin
        start_mask |= dutStart;
        starts++;
        if (v.done_dly >= 0) done_at = cyc + v.done_dly;
      end
      if (transmit && tx_first < 0) tx_first = cyc;
      if (clearDR) begin ack_seen = 1; dataReceived = 1'b0; end
      if (ack_seen && !busy) finished = 1;
      dutDone = '0; dutResult = '0;
      if (v.noise && (cyc % 3 == 0)) begin dutDone[0] = 1'b1; dutResult[31:0] = 32'hFFFF_FFFF; end
      if (cyc == done_at && t < NT) begin dutDone[t] = 1'b1; dutResult[t*32 +: 32] = v.res; end
      case (tx_state)
        0: if (transmit) begin tx_state = 1; tx_cnt = 2; end
        1: begin tx_cnt--; if (tx_cnt == 0) begin transmitting = 1'b1; tx_state = 2; tx_cnt = 3; end end
        2: begin tx_cnt--; if (tx_cnt == 0) begin transmitting = 1'b0; tx_state = 3; end end
        default: ;
      endcase
    end
    dutDone = '0; dutResult = '0; dataReceived = 1'b0; transmitting = 1'b0;
    chk({v.name, "_completed"}, 64'(finished), 64'd1);
    chk({v.name, "_start_mask"}, 64'(start_mask), 64'(v.exp_start));
    chk({v.name, "_start_pulses"}, 64'(starts), (v.exp_start != 0) ? 64'd1 : 64'd0);
    chk({v.name, "_transmitted"}, 64'(tx_first >= 0), 64'(v.resp));
    if (v.chk_lat) chk({v.name, "_latency"}, 64'(tx_first), 64'd3);
    if (v.exp_start != 0) begin
      chk({v.name, "_dut_cmd"}, 64'(dutCommand), 64'(v.ctrl[3:0]));
      chk({v.name, "_dut_data"}, 64'(dutData), 64'(v.data));
    end
  endtask

  initial begin
    bit ok;
    bit stray;
    reset = 1'b1; dataReceived = 1'b0; control = '0; inputData = '0;
    transmitting = 1'b0; dutDone = '0; dutResult = '0;

    #3;
    chk("reset_outputs", {clearDR, transmit, hostStatus, hostData, dutStart, dutCommand, dutData, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    vecs.push_back(mk("ping0", 8'h00, 32'hDEAD_BEEF, -1, 32'h0, 0, 1, 0, 0, 32'hDEAD_BEEF, 3'b000, 1));
    vecs.push_back(mk("ping1", 8'h0A, 32'h0BAD_F00D, -1, 32'h0, 0, 1, 0, 0, 32'h0BAD_F00D, 3'b000, 1));
    vecs.push_back(mk("exec_t1", 8'h53, 32'hA5A5_0001, 10, 32'h1234_5678, 0, 1, 0, 0, 32'h1234_5678, 3'b010, 0));
    vecs.push_back(mk("quiet_tmo", 8'h60, 32'h0000_0042, -1, 32'h0, 1, 1, 0, 1, 32'h0, 3'b100, 0));
    vecs.push_back(mk("bad_target", 8'h70, 32'h1111_2222, -1, 32'h0, 0, 1, 1, 0, 32'h0, 3'b000, 0));
`ifdef WIDE_UART_SEQ_LOOPBACK_EN
    vecs.push_back(mk("opcode11", 8'hC5, 32'h1357_2468, -1, 32'h0, 0, 1, 0, 0, 32'h1357_246D, 3'b000, 0));
`else
    vecs.push_back(mk("opcode11", 8'hC5, 32'h1357_2468, -1, 32'h0, 0, 1, 1, 0, 32'h0, 3'b000, 0));
`endif
    // Timer holds TMO+1 waiting cycles: done at offset TMO+1 is the expiry cycle.
    vecs.push_back(mk("done_on_expiry", 8'h41, 32'h0000_0007, TMO + 1, 32'hCAFE_F00D, 0, 1, 0, 0, 32'hCAFE_F00D, 3'b001, 0));
    vecs.push_back(mk("done_after_expiry", 8'h42, 32'h0000_0008, TMO + 2, 32'hCAFE_F00D, 0, 1, 0, 1, 32'h0, 3'b001, 0));
    vecs.push_back(mk("quiet_done", 8'h94, 32'h5555_AAAA, 5, 32'h7777_7777, 0, 0, 0, 0, 32'h0, 3'b010, 0));
    vecs.push_back(mk("exec_t2_noise", 8'h6F, 32'h0000_00F0, 7, 32'h8765_4321, 1, 1, 0, 0, 32'h8765_4321, 3'b100, 0));

    foreach (vecs[i]) send(vecs[i]);

    // Sequence number wrap: enough pings to pass 16 responses.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] d;
      d = $urandom;
      send(mk("ping_wrap", 8'h00, d, -1, 32'h0, 0, 1, 0, 0, d, 3'b000, 0));
    end

    // Reset while a command is waiting for done.
    @(posedge clk); #1;
    control = 8'h51; inputData = 32'h0F0F_0F0F; dataReceived = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (dutStart != '0) ok = 1;
    end
    chk("rst_mid_start_seen", 64'(ok), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_busy_before", 64'(busy), 64'd1);
    chk("rst_mid_cmd_before", 64'(dutCommand), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_async_outputs", {clearDR, transmit, hostStatus, hostData, dutStart, dutCommand, dutData, busy}, 64'd0);
    dataReceived = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (dutStart != '0 || busy || transmit) stray = 1;
    end
    chk("rst_mid_no_restart", 64'(stray), 64'd0);
    exp_seq = 4'd0;
    send(mk("ping_after_reset", 8'h00, 32'hFACE_0001, -1, 32'h0, 0, 1, 0, 0, 32'hFACE_0001, 3'b000, 1));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wide_uart_dut_sequencer.md
Name: wide_uart_dut_sequencer

Overview:
Command sequencer between the wide UART I/O block and up to four DUT channels. It takes each host packet, decodes the control byte into opcode, target and sub-command, and starts the selected DUT channel. It then waits for done or timeout, sends a status byte plus result data back to the host, and finally acknowledges receipt so the next packet can be accepted.

Parameters:
WIDTH, 4, data width in bytes; must match the UART I/O block.
NUM_TARGETS, 4, number of DUT channels, 1..4.
TIMEOUT_CYCLES, 1000000, maximum masterClock cycles to wait for dutDone; must be at least 1.
TIMER_BITS, $clog2(TIMEOUT_CYCLES+1), derived width of the timeout counter.

Ports:
masterClock  in  1  single clock for the whole block.
reset  in  1  asynchronous, active-high; all state clears immediately.
dataReceived  in  1  full packet present in the UART I/O block.
control  in  8  received control byte.
inputData  in  WIDTH*8  received data.
clearDR  out  1  acknowledges the received packet.
transmit  out  1  requests a response transmission.
transmitting  in  1  UART I/O block busy transmitting.
hostStatus  out  8  status byte of the response.
hostData  out  WIDTH*8  data bytes of the response.
dutStart  out  NUM_TARGETS  one-hot, one-cycle start pulse.
dutCommand  out  4  sub-command, control[3:0], held from START until the next packet.
dutData  out  WIDTH*8  operand, inputData, held the same way.
dutDone  in  NUM_TARGETS  per-channel done pulse or level.
dutResult  in  NUM_TARGETS*WIDTH*8  flat result bus; channel k occupies bits [k*W8 +: W8].
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, sequence counter 0, state IDLE.
- Control byte decode: [7:6] opcode (00 PING, 01 EXEC, 10 EXEC_QUIET, 11 reserved); [5:4] target; [3:0] sub-command.
- IDLE: leave to DECODE on the first cycle dataReceived=1. control, inputData and target are latched on that same edge.
- DECODE, one cycle:
  - PING goes to LOAD_TX with data = inputData.
  - Reserved opcode, or target >= NUM_TARGETS, sets the error flag and goes to LOAD_TX with data = 0.
  - EXEC and EXEC_QUIET go to START.
- START, one cycle: dutStart[target]=1, timer loaded with TIMEOUT_CYCLES; go to WAIT_DONE.
- WAIT_DONE:
  - Only dutDone[target] is observed; done on other channels is ignored.
  - Done captures dutResult[target] in the same cycle, then goes to LOAD_TX (EXEC) or ACK (EXEC_QUIET).
  - The timer decrements each cycle; at 0 without done, the timeout flag is set, data = 0, go to LOAD_TX. This applies to EXEC_QUIET too: a timeout always produces a response.
  - Done on the expiry cycle wins over timeout.
- LOAD_TX, one cycle:
  - hostStatus = {error, timeout, target[1:0], seq[3:0]}; hostData = captured data.
  - seq increments after each response and wraps 15 to 0.
- TX_REQ: transmit=1 until transmitting=1 is seen, then transmit=0 and go to TX_WAIT.
- TX_WAIT: wait for transmitting=0, then go to ACK. hostStatus and hostData stay stable from LOAD_TX until ACK exits.
- ACK: clearDR=1 until dataReceived=0, then clearDR=0, clear flags, go to IDLE.
- Latency: a PING response asserts transmit exactly 3 cycles after dataReceived rises. With dataReceived sampled at edge 0, edges 1–2 are DECODE and LOAD_TX; transmit is registered high from edge 3.
- dataReceived while not in IDLE is ignored; the UART I/O block holds the packet until ACK.
- Reset mid-transfer: outputs drop immediately; any in-flight DUT operation is abandoned, with no start re-issued.
- Widths: result selection uses an indexed part-select; the timer never underflows below 0.

Optional Feature:
WIDE_UART_SEQ_LOOPBACK_EN.
- Defined: opcode 11 is LOOPBACK. The response is data = inputData, with control[3:0] XORed into the low nibble of byte 0; status error=0; no DUT start.
- Undefined: opcode 11 sets error with data = 0.

Decomposition:
- Package wide_uart_seq_pkg: opcode constants, state encoding, status bit positions (ERR=7, TMO=6, TGT=5:4, SEQ=3:0).
- One sub-module, wide_uart_seq_timer: loadable down-counter with expired flag, parameterised by TIMER_BITS.

Test Plan:
- PING: control=0x00, inputData=0xDEADBEEF -> transmit after 3 cycles; hostStatus=0x00, hostData=0xDEADBEEF; clearDR, then IDLE; next status seq=1.
- EXEC: control=0x53 → target 1, sub-command 3; dutDone[1] 10 cycles later with result 0x12345678 -> dutStart=0b0010 for one cycle, dutCommand=3; hostStatus=0x10, hostData=0x12345678.
- Timeout: TIMEOUT_CYCLES=16, control=0x60 (EXEC_QUIET, target 2), no done -> hostStatus=0x60, hostData=0; dutDone[0] pulses during the wait are ignored.
- Boundaries:
  - NUM_TARGETS=3, control=0x70 -> error; hostStatus=0xB0, no dutStart.
  - Opcode 0xC0 without the macro -> hostStatus=0x80.
  - Opcode 0xC5 with the macro -> data echo with low nibble XOR 5.
- Edge cases:
  - Done on the exact expiry cycle -> no timeout flag.
  - 17 responses -> seq wraps to 0 on the 17th.
  - Reset asserted during WAIT_DONE -> all outputs 0 asynchronously, state IDLE.
